// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer and its downstream detector bench.
package seq_bit_serializer_pkg;

    localparam int unsigned SER_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out stage with a one-word holding register for zero-bubble streaming.
// Feeds one bit per clk to the downstream Mealy sequence detector.
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept_c;
    logic             last_bit_c;
    logic [WIDTH-1:0] shifted_c;

    // Move the register one place toward the output end, zero filling behind.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted_c = {shreg_q[WIDTH-2:0], 1'b0};
            assign ser_out   = shreg_q[WIDTH-1];
        end else begin : g_lsb
            assign shifted_c = {1'b0, shreg_q[WIDTH-1:1]};
            assign ser_out   = shreg_q[0];
        end
    endgenerate

    assign din_ready  = rst && !hold_full_q;
    assign accept_c   = din_valid && din_ready;
    assign last_bit_c = (cnt_q == CNT_LAST);
    assign ser_valid  = (state_q == SHIFT);
    assign word_done  = ser_valid && last_bit_c;
    assign busy       = ser_valid || hold_full_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // On the last bit a held word wins over a fresh accept; an empty pipe drops to IDLE.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit_c) begin
                    shreg_d = shifted_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (accept_c) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    shreg_d     = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                end else if (accept_c) begin
                    shreg_d = din;
                    cnt_d   = '0;
                end else begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: vector table plus streaming and mid-word reset sequences.
module tb_seq_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic m_ready, m_so, m_sv, m_wd, m_busy;
    logic l_ready, l_so, l_sv, l_wd, l_busy;

    int errors = 0;
    int checks = 0;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (m_ready),
        .ser_out   (m_so),
        .ser_valid (m_sv),
        .word_done (m_wd),
        .busy      (m_busy)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (l_ready),
        .ser_out   (l_so),
        .ser_valid (l_sv),
        .word_done (l_wd),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    typedef struct {
        logic       rst;
        logic       dv;
        logic [7:0] din;
        bit         lsb;
        logic       so;
        logic       sv;
        logic       wd;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic dv, input logic [7:0] d, input bit lsb,
                       input logic so, input logic sv, input logic wd, input logic bz,
                       input logic rdy);
        vec_t v;
        v.rst = r; v.dv = dv; v.din = d; v.lsb = lsb;
        v.so = so; v.sv = sv; v.wd = wd; v.busy = bz; v.rdy = rdy;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic so, input logic sv, input logic wd,
                           input logic bz, input logic rdy);
        chk({tag, " ser_out"}, m_so, so);
        chk({tag, " ser_valid"}, m_sv, sv);
        chk({tag, " word_done"}, m_wd, wd);
        chk({tag, " busy"}, m_busy, bz);
        chk({tag, " din_ready"}, m_ready, rdy);
    endtask

    initial begin
        logic [7:0] wc8;
        logic [7:0] wa5;
        logic [7:0] w13;
        logic [7:0] words[$];
        wc8 = 8'hC8;
        wa5 = 8'hA5;
        w13 = 8'h13;
        rst = 1'b0;
        din = '0;
        din_valid = 1'b0;

        // Reset held three cycles with din_valid high, then release.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 8'hC8, 0, 0, 0, 0, 0, 0);
        add(1'b1, 1'b1, 8'hC8, 0, 0, 0, 0, 0, 1);
        // Single word 0xC8 MSB first.
        for (int i = 0; i < 8; i++)
            add(1'b1, 1'b0, 8'h00, 0, wc8[7-i], 1, (i == 7), 1, 1);
        add(1'b1, 1'b0, 8'h00, 0, 0, 0, 0, 0, 1);
        // Back-to-back 0xC8 then 0xA5; 0xFF offered while not ready must be ignored.
        add(1'b1, 1'b1, 8'hC8, 0, 0, 0, 0, 0, 1);
        add(1'b1, 1'b1, 8'hA5, 0, wc8[7], 1, 0, 1, 1);
        for (int i = 1; i < 8; i++)
            add(1'b1, 1'b1, 8'hFF, 0, wc8[7-i], 1, (i == 7), 1, 0);
        for (int i = 0; i < 8; i++)
            add(1'b1, 1'b0, 8'h00, 0, wa5[7-i], 1, (i == 7), 1, 1);
        add(1'b1, 1'b0, 8'h00, 0, 0, 0, 0, 0, 1);
        // LSB-first instance with 0x13.
        add(1'b1, 1'b1, 8'h13, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add(1'b1, 1'b0, 8'h00, 1, w13[i], 1, (i == 7), 1, 1);
        add(1'b1, 1'b0, 8'h00, 1, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            din_valid = vecs[i].dv;
            din       = vecs[i].din;
            #1;
            chk($sformatf("vec%0d ser_out", i), vecs[i].lsb ? l_so : m_so, vecs[i].so);
            chk($sformatf("vec%0d ser_valid", i), m_sv, vecs[i].sv);
            chk($sformatf("vec%0d word_done", i), m_wd, vecs[i].wd);
            chk($sformatf("vec%0d busy", i), m_busy, vecs[i].busy);
            chk($sformatf("vec%0d din_ready", i), m_ready, vecs[i].rdy);
        end

        // Backpressure: new din every cycle with din_valid high; accepts at t=0,1,9,17,...
        for (int t = 0; t <= 50; t++) begin
            logic       exp_rdy;
            logic       exp_sv;
            logic       exp_so;
            logic [7:0] w;
            @(negedge clk);
            din_valid = (t < 40);
            din       = 8'(t * 37 + 11);
            #1;
            exp_rdy = (t <= 1) || (t >= 41) || (((t - 1) % 8) == 0);
            if (exp_rdy && din_valid) words.push_back(din);
            exp_sv = (t >= 1) && (t <= 48);
            exp_so = 1'b0;
            if (exp_sv) begin
                if (((t - 1) / 8) < words.size()) begin
                    w = words[(t - 1) / 8];
                    exp_so = w[7 - ((t - 1) % 8)];
                end else begin
                    exp_so = ~m_so;
                end
            end
            chk($sformatf("bp t%0d din_ready", t), m_ready, exp_rdy);
            chk($sformatf("bp t%0d ser_valid", t), m_sv, exp_sv);
            chk($sformatf("bp t%0d ser_out", t), m_so, exp_so);
            chk($sformatf("bp t%0d word_done", t), m_wd, exp_sv && (((t - 1) % 8) == 7));
        end
        chk("bp word count", 1'(words.size() == 6), 1'b1);

        // Mid-word reset with a word in hold.
        @(negedge clk); din_valid = 1'b1; din = 8'hC8; #1;
        chk_all("mr idle", 0, 0, 0, 0, 1);
        @(negedge clk); din = 8'hA5; #1;
        chk_all("mr b0", 1, 1, 0, 1, 1);
        @(negedge clk); din_valid = 1'b0; #1;
        chk_all("mr b1", 1, 1, 0, 1, 0);
        @(negedge clk); #1;
        chk_all("mr b2", 0, 1, 0, 1, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk_all("mr assert", 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk_all($sformatf("mr hold%0d", i), 0, 0, 0, 0, 0);
        end
        @(negedge clk); rst = 1'b1; #1;
        chk_all("mr release", 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk_all($sformatf("mr quiet%0d", i), 0, 0, 0, 0, 1);
        end
        @(negedge clk); din_valid = 1'b1; din = 8'h80; #1;
        @(negedge clk); din_valid = 1'b0; #1;
        chk_all("mr new b0", 1, 1, 0, 1, 1);
        @(negedge clk); #1;
        chk_all("mr new b1", 0, 1, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
